// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle CPU control FSM (IF/ID/EXE/MEM/WB), optional MC_CONTROL_ILLEGAL_TRAP_EN
// Only the state (and the sticky illegal flag when trapping) is registered; all strobes are decoded combinationally.
module mc_control #(
  parameter int          RA_REG  = 31,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] func,
  input  logic [4:0] rt,
  input  logic       zero,
  input  logic       sign,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       DBDataSrc,
  output logic       ExtSel,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       mRD,
  output logic       mWR,
  output logic [3:0] state,
  output logic       halted
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  ,
  output logic       illegal
`endif
);

  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_LS = 4'b0010,
    S_MEM    = 4'b0011,
    S_WB_LD  = 4'b0100,
    S_EXE_BR = 4'b0101,
    S_EXE_AL = 4'b0110,
    S_WB_AL  = 4'b0111,
    S_HALT   = 4'b1000
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_REG    = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  // The jal target register is chosen inside the datapath; only its select code lives here.
  generate
    if (RA_REG < 1 || RA_REG > 31) begin : g_ra_reg_out_of_range
    end
  endgenerate

  state_t state_q, state_d;

  logic       is_rtype;
  logic       dec_al, dec_br, dec_ls, dec_j, dec_jal, dec_jr, dec_halt, dec_legal;
  logic [3:0] dec_alu_op;
  logic       br_taken;
  logic       pc_wre_c, reg_wre_c, m_wr_c;

  assign is_rtype = (Opcode == OP_RTYPE);

  always_comb begin
    dec_al     = 1'b0;
    dec_br     = 1'b0;
    dec_ls     = 1'b0;
    dec_j      = 1'b0;
    dec_jal    = 1'b0;
    dec_jr     = 1'b0;
    dec_halt   = 1'b0;
    dec_alu_op = ALU_ADD;
    if (Opcode == HALT_OP) begin
      dec_halt = 1'b1;
    end else begin
      case (Opcode)
        OP_RTYPE: begin
          case (func)
            F_ADD:   begin dec_al = 1'b1; dec_alu_op = ALU_ADD; end
            F_SUB:   begin dec_al = 1'b1; dec_alu_op = ALU_SUB; end
            F_AND:   begin dec_al = 1'b1; dec_alu_op = ALU_AND; end
            F_OR:    begin dec_al = 1'b1; dec_alu_op = ALU_OR;  end
            F_SLT:   begin dec_al = 1'b1; dec_alu_op = ALU_SLT; end
            F_SLL:   begin dec_al = 1'b1; dec_alu_op = ALU_SLL; end
            F_JR:    dec_jr = 1'b1;
            default: ;
          endcase
        end
        OP_ADDI: begin dec_al = 1'b1; dec_alu_op = ALU_ADD; end
        OP_ORI:  begin dec_al = 1'b1; dec_alu_op = ALU_OR;  end
        OP_SLTI: begin dec_al = 1'b1; dec_alu_op = ALU_SLT; end
        OP_LW, OP_SW:   dec_ls = 1'b1;
        OP_BEQ, OP_BNE: dec_br = 1'b1;
        // bltz compares rs against $0, so any other rt is not an encoding we know
        OP_BLTZ: dec_br = (rt == 5'd0);
        OP_J:    dec_j = 1'b1;
        OP_JAL:  dec_jal = 1'b1;
        default: ;
      endcase
    end
    dec_legal = dec_al | dec_br | dec_ls | dec_j | dec_jal | dec_jr | dec_halt;
  end

  always_comb begin
    case (Opcode)
      OP_BEQ:  br_taken = zero;
      OP_BNE:  br_taken = ~zero;
      default: br_taken = sign;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_wre_c  = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    reg_wre_c = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    ExtSel    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = ALU_ADD;
    PCSrc     = PC_NEXT;
    mRD       = 1'b0;
    m_wr_c    = 1'b0;
    case (state_q)
      S_IF: begin
        InsMemRW = 1'b1;
        IRWre    = 1'b1;
        state_d  = S_ID;
      end
      S_ID: begin
        if (dec_halt) begin
          state_d = S_HALT;
        end else if (dec_j) begin
          PCSrc    = PC_JUMP;
          pc_wre_c = 1'b1;
          state_d  = S_IF;
        end else if (dec_jal) begin
          PCSrc     = PC_JUMP;
          pc_wre_c  = 1'b1;
          reg_wre_c = 1'b1;
          RegDst    = 2'b10;
          WrRegDSrc = 1'b0;
          state_d   = S_IF;
        end else if (dec_jr) begin
          PCSrc    = PC_REG;
          pc_wre_c = 1'b1;
          state_d  = S_IF;
        end else if (dec_br) begin
          state_d = S_EXE_BR;
        end else if (dec_ls) begin
          state_d = S_EXE_LS;
        end else if (!dec_legal) begin
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          pc_wre_c = 1'b1;
          state_d  = S_IF;
`endif
        end else begin
          state_d = S_EXE_AL;
        end
      end
      S_EXE_AL: begin
        ALUSrcA = (is_rtype && func == F_SLL) ? 2'b01 : 2'b00;
        ALUSrcB = is_rtype ? 2'b00 : 2'b01;
        ExtSel  = (Opcode != OP_ORI);
        ALUOp   = dec_alu_op;
        state_d = S_WB_AL;
      end
      S_WB_AL: begin
        reg_wre_c = 1'b1;
        WrRegDSrc = 1'b1;
        RegDst    = is_rtype ? 2'b01 : 2'b00;
        pc_wre_c  = 1'b1;
        state_d   = S_IF;
      end
      S_EXE_BR: begin
        ALUOp    = ALU_SUB;
        ExtSel   = 1'b1;
        pc_wre_c = 1'b1;
        PCSrc    = br_taken ? PC_BRANCH : PC_NEXT;
        state_d  = S_IF;
      end
      S_EXE_LS: begin
        ALUOp   = ALU_ADD;
        ALUSrcB = 2'b01;
        ExtSel  = 1'b1;
        state_d = S_MEM;
      end
      S_MEM: begin
        if (Opcode == OP_SW) begin
          m_wr_c   = 1'b1;
          pc_wre_c = 1'b1;
          state_d  = S_IF;
        end else if (Opcode == OP_LW) begin
          mRD     = 1'b1;
          state_d = S_WB_LD;
        end else begin
          state_d = S_IF;
        end
      end
      S_WB_LD: begin
        mRD       = 1'b1;
        DBDataSrc = 1'b1;
        WrRegDSrc = 1'b1;
        reg_wre_c = 1'b1;
        pc_wre_c  = 1'b1;
        state_d   = S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // An asserted reset aborts the instruction in flight, so its architectural writes are suppressed at once.
  assign PCWre  = pc_wre_c & ~reset;
  assign RegWre = reg_wre_c & ~reset;
  assign mWR    = m_wr_c & ~reset;

  assign state  = state_q;
  assign halted = (state_q == S_HALT);

`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if (state_q == S_ID && !dec_legal) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
`endif

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - self-checking bench for mc_control
// Per-instruction cycle recipes predict every output; a negedge process compares them against the DUT.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode, func;
  logic [4:0] rt;
  logic       zero, sign;
  logic       PCWre, IRWre, InsMemRW, RegWre, WrRegDSrc, DBDataSrc, ExtSel, mRD, mWR, halted;
  logic [1:0] RegDst, ALUSrcA, ALUSrcB, PCSrc;
  logic [3:0] ALUOp, state;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  mc_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .func(func), .rt(rt), .zero(zero), .sign(sign),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .RegWre(RegWre), .RegDst(RegDst),
    .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc), .ExtSel(ExtSel), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .mRD(mRD), .mWR(mWR), .state(state),
    .halted(halted)
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [3:0] ST_IF = 4'b0000, ST_ID = 4'b0001, ST_EXE_AL = 4'b0110, ST_WB_AL = 4'b0111;
  localparam logic [3:0] ST_EXE_BR = 4'b0101, ST_EXE_LS = 4'b0010, ST_MEM = 4'b0011;
  localparam logic [3:0] ST_WB_LD = 4'b0100, ST_HALT = 4'b1000;

  typedef struct packed {
    logic [3:0] st;
    logic       pcwre, irwre, insmem, regwre;
    logic [1:0] regdst;
    logic       wrsrc, dbsrc, ext;
    logic [1:0] srca, srcb;
    logic [3:0] aluop;
    logic [1:0] pcsrc;
    logic       mrd, mwr, halted;
  } exp_t;

  exp_t  exp_q[$];
  string lbl_q[$];
  exp_t  plan_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic [3:0] seen[16];
  int    pcw_cnt;

  function automatic exp_t act_vec();
    exp_t a;
    a.st = state; a.pcwre = PCWre; a.irwre = IRWre; a.insmem = InsMemRW; a.regwre = RegWre;
    a.regdst = RegDst; a.wrsrc = WrRegDSrc; a.dbsrc = DBDataSrc; a.ext = ExtSel;
    a.srca = ALUSrcA; a.srcb = ALUSrcB; a.aluop = ALUOp; a.pcsrc = PCSrc;
    a.mrd = mRD; a.mwr = mWR; a.halted = halted;
    return a;
  endfunction

  always @(negedge clk) begin
    exp_t e, a;
    string l;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      l = lbl_q.pop_front();
      a = act_vec();
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: outputs got %h want %h", l, a, e);
      end
    end
    n_cmp++;
    if (RegWre === 1'b1 && mWR === 1'b1) begin
      n_bad++;
      $display("FAIL regwre_mwr_exclusive: got RegWre=1 mWR=1 want not both at %0t", $time);
    end
  end

  task automatic lit(input string nm, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  function automatic exp_t rec(input logic [3:0] st);
    exp_t r;
    r = '0;
    r.st = st;
    r.halted = (st == ST_HALT);
    return r;
  endfunction

  function automatic string kind_of(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rtv);
    if (op == 6'b111111) return "halt";
    case (op)
      6'b000000: case (fn)
                   6'b100000: return "add";
                   6'b100010: return "sub";
                   6'b100100: return "and";
                   6'b100101: return "or";
                   6'b101010: return "slt";
                   6'b000000: return "sll";
                   6'b001000: return "jr";
                   default:   return "ill";
                 endcase
      6'b001000: return "addi";
      6'b001101: return "ori";
      6'b001010: return "slti";
      6'b100011: return "lw";
      6'b101011: return "sw";
      6'b000100: return "beq";
      6'b000101: return "bne";
      6'b000001: return (rtv == 5'd0) ? "bltz" : "ill";
      6'b000010: return "j";
      6'b000011: return "jal";
      default:   return "ill";
    endcase
  endfunction

  function automatic logic [3:0] alu_code(input string k);
    if (k == "sub") return 4'b0001;
    if (k == "and") return 4'b0010;
    if (k == "or" || k == "ori") return 4'b0011;
    if (k == "slt" || k == "slti") return 4'b0100;
    if (k == "sll") return 4'b0101;
    return 4'b0000;
  endfunction

  task automatic plan(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rtv,
                      input logic z, input logic s);
    exp_t  r;
    string k;
    logic  taken;
    plan_q.delete();
    k = kind_of(op, fn, rtv);
    r = rec(ST_IF); r.irwre = 1; r.insmem = 1; plan_q.push_back(r);
    r = rec(ST_ID);
    if (k == "j") begin
      r.pcsrc = 2'b11; r.pcwre = 1; plan_q.push_back(r);
    end else if (k == "jal") begin
      r.pcsrc = 2'b11; r.pcwre = 1; r.regwre = 1; r.regdst = 2'b10; plan_q.push_back(r);
    end else if (k == "jr") begin
      r.pcsrc = 2'b10; r.pcwre = 1; plan_q.push_back(r);
    end else if (k == "halt") begin
      plan_q.push_back(r);
    end else if (k == "ill") begin
`ifndef MC_CONTROL_ILLEGAL_TRAP_EN
      r.pcwre = 1;
`endif
      plan_q.push_back(r);
    end else if (k == "beq" || k == "bne" || k == "bltz") begin
      plan_q.push_back(r);
      taken = (k == "beq") ? z : (k == "bne") ? !z : s;
      r = rec(ST_EXE_BR); r.aluop = 4'b0001; r.ext = 1; r.pcwre = 1;
      r.pcsrc = taken ? 2'b01 : 2'b00;
      plan_q.push_back(r);
    end else if (k == "lw" || k == "sw") begin
      plan_q.push_back(r);
      r = rec(ST_EXE_LS); r.srcb = 2'b01; r.ext = 1; plan_q.push_back(r);
      r = rec(ST_MEM);
      if (k == "lw") begin
        r.mrd = 1; plan_q.push_back(r);
        r = rec(ST_WB_LD); r.mrd = 1; r.dbsrc = 1; r.wrsrc = 1; r.regwre = 1; r.pcwre = 1;
        plan_q.push_back(r);
      end else begin
        r.mwr = 1; r.pcwre = 1; plan_q.push_back(r);
      end
    end else begin
      plan_q.push_back(r);
      r = rec(ST_EXE_AL); r.aluop = alu_code(k);
      r.srca = (k == "sll") ? 2'b01 : 2'b00;
      r.srcb = (op == 6'b000000) ? 2'b00 : 2'b01;
      r.ext = (k == "ori") ? 1'b0 : 1'b1;
      plan_q.push_back(r);
      r = rec(ST_WB_AL); r.regwre = 1; r.wrsrc = 1; r.pcwre = 1;
      r.regdst = (op == 6'b000000) ? 2'b01 : 2'b00;
      plan_q.push_back(r);
    end
  endtask

  task automatic push_exp(input exp_t e, input string nm);
    exp_q.push_back(e);
    lbl_q.push_back(nm);
  endtask

  task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                     input logic [4:0] rtv, input logic z, input logic s);
    int n;
    plan(op, fn, rtv, z, s);
    n = plan_q.size();
    Opcode = op; func = fn; rt = rtv; zero = z; sign = s;
    pcw_cnt = 0;
    for (int i = 0; i < n; i++) begin
      push_exp(plan_q[i], $sformatf("%s[%0d]", name, i));
      #1;
      seen[i] = state;
      pcw_cnt += int'(PCWre);
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_pulse(input string name, input exp_t cur);
    reset = 1'b1;
    cur.regwre = 0; cur.mwr = 0; cur.pcwre = 0;
    push_exp(cur, name);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic run_abort(input string name, input logic [5:0] op, input logic [5:0] fn, input int at);
    plan(op, fn, 5'd0, 1'b0, 1'b0);
    Opcode = op; func = fn; rt = 5'd0; zero = 1'b0; sign = 1'b0;
    for (int i = 0; i < at; i++) begin
      push_exp(plan_q[i], $sformatf("%s[%0d]", name, i));
      @(posedge clk); #1;
    end
    reset_pulse($sformatf("%s_abort", name), plan_q[at]);
  endtask

  task automatic idle(input string name, input int n, input logic [3:0] st);
    pcw_cnt = 0;
    for (int i = 0; i < n; i++) begin
      push_exp(rec(st), $sformatf("%s[%0d]", name, i));
      #1;
      pcw_cnt += int'(PCWre);
      @(posedge clk); #1;
    end
  endtask

  task automatic illegal_case(input string name, input logic [5:0] op, input logic [5:0] fn,
                              input logic [4:0] rtv);
    run(name, op, fn, rtv, 1'b0, 1'b0);
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    idle({name, "_halt"}, 2, ST_HALT);
    lit({name, "_illegal_set"}, int'(illegal), 1);
    reset_pulse({name, "_reset"}, rec(ST_HALT));
    #1;
    lit({name, "_illegal_clr"}, int'(illegal), 0);
`else
    lit({name, "_nop_len"}, plan_q.size(), 2);
    lit({name, "_nop_pcwre"}, pcw_cnt, 1);
`endif
  endtask

  initial begin
    exp_t r;
    reset = 1'b1; Opcode = 6'b000000; func = 6'b100000; rt = 5'd2; zero = 1'b0; sign = 1'b0;

    plan(6'b100011, 6'b0, 5'd0, 1'b0, 1'b0); lit("model_lw_len", plan_q.size(), 5);
    plan(6'b101011, 6'b0, 5'd0, 1'b0, 1'b0); lit("model_sw_len", plan_q.size(), 4);
    plan(6'b000100, 6'b0, 5'd0, 1'b1, 1'b0); lit("model_beq_len", plan_q.size(), 3);
    lit("model_beq_taken_pcsrc", int'(plan_q[2].pcsrc), 1);
    plan(6'b000000, 6'b100010, 5'd0, 1'b0, 1'b0); lit("model_sub_aluop", int'(plan_q[2].aluop), 1);
    plan(6'b000011, 6'b0, 5'd0, 1'b0, 1'b0); lit("model_jal_regdst", int'(plan_q[1].regdst), 2);

    @(posedge clk); #1;
    r = rec(ST_IF); r.irwre = 1; r.insmem = 1;
    push_exp(r, "reset_hold");
    #1;
    lit("reset_state", int'(state), 0);
    lit("reset_pcwre", int'(PCWre), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    run("add", 6'b000000, 6'b100000, 5'd2, 1'b0, 1'b0);
    lit("add_id_state", int'(seen[1]), 1);
    lit("add_exe_state", int'(seen[2]), 6);
    lit("add_wb_state", int'(seen[3]), 7);
    lit("add_pcwre_once", pcw_cnt, 1);
    run("sub",  6'b000000, 6'b100010, 5'd2, 1'b0, 1'b0);
    run("and",  6'b000000, 6'b100100, 5'd2, 1'b0, 1'b0);
    run("or",   6'b000000, 6'b100101, 5'd2, 1'b0, 1'b0);
    run("slt",  6'b000000, 6'b101010, 5'd2, 1'b0, 1'b0);
    run("sll",  6'b000000, 6'b000000, 5'd2, 1'b0, 1'b0);
    run("addi", 6'b001000, 6'b010101, 5'd4, 1'b0, 1'b0);
    run("ori",  6'b001101, 6'b111111, 5'd4, 1'b0, 1'b0);
    run("slti", 6'b001010, 6'b000001, 5'd4, 1'b0, 1'b0);
    run("lw",   6'b100011, 6'b000000, 5'd5, 1'b0, 1'b0);
    lit("lw_pcwre_once", pcw_cnt, 1);
    run("sw",   6'b101011, 6'b000000, 5'd5, 1'b0, 1'b0);
    run("beq_t",  6'b000100, 6'b0, 5'd1, 1'b1, 1'b0);
    run("beq_nt", 6'b000100, 6'b0, 5'd1, 1'b0, 1'b1);
    run("bne_t",  6'b000101, 6'b0, 5'd1, 1'b0, 1'b0);
    run("bne_nt", 6'b000101, 6'b0, 5'd1, 1'b1, 1'b0);
    run("bltz_t",  6'b000001, 6'b0, 5'd0, 1'b0, 1'b1);
    run("bltz_nt", 6'b000001, 6'b0, 5'd0, 1'b1, 1'b0);
    run("j",   6'b000010, 6'b0, 5'd0, 1'b0, 1'b0);
    run("jal", 6'b000011, 6'b0, 5'd0, 1'b0, 1'b0);
    lit("jal_pcwre_once", pcw_cnt, 1);
    run("jr",  6'b000000, 6'b001000, 5'd0, 1'b0, 1'b0);

    illegal_case("ill_op",   6'b010101, 6'b000000, 5'd0);
    illegal_case("ill_func", 6'b000000, 6'b111111, 5'd0);
    illegal_case("ill_bltz", 6'b000001, 6'b000000, 5'd3);

    run_abort("add_rst", 6'b000000, 6'b100000, 3);
    run_abort("sw_rst",  6'b101011, 6'b000000, 3);
    run_abort("lw_rst",  6'b100011, 6'b000000, 4);

    run("halt", 6'b111111, 6'b0, 5'd0, 1'b0, 1'b0);
    idle("halted", 10, ST_HALT);
    lit("halt_no_pcwre", pcw_cnt, 0);
    lit("halt_flag", int'(halted), 1);
    reset_pulse("halt_reset", rec(ST_HALT));
    run("add_after_halt", 6'b000000, 6'b100000, 5'd2, 1'b0, 1'b0);
    lit("after_halt_if", int'(seen[0]), 0);

    lit("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
